vector_lane_sequencer: RTL and testbench

- Multi-cycle replacement for the combinational 4-lane vector ALU: time-multiplexes one 32-bit lane ALU across all lanes, one lane per cycle.
- Sits between decode/control and the vector register file. Latches operands on start, assembles a 128-bit result, issues a single write-back pulse, and stalls the PC while busy.

---
 rtl/vseq_pkg.sv | 19 +
 rtl/vlane_alu.sv | 33 +++
 rtl/vector_lane_sequencer.sv | 138 +++++++++++++
 tb/tb_vector_lane_sequencer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/vseq_pkg.sv
// Shared definitions for the vector lane sequencer:
// op encodings, FSM states and default geometry.
package vseq_pkg;

    localparam int LANES_DEF = 4;
    localparam int XLEN_DEF  = 32;

    localparam logic [2:0] VOP_ADD = 3'b000;
    localparam logic [2:0] VOP_MUL = 3'b001;
    localparam logic [2:0] VOP_SUB = 3'b010;
    localparam logic [2:0] VOP_DIV = 3'b011;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        WB
    } vseq_state_e;

endpackage

// File: rtl/vlane_alu.sv
// Single-lane unsigned ALU: add/sub/mul/div, modulo 2^XLEN.
// Division by zero yields 0 and raises dz_o.
module vlane_alu
    import vseq_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic [XLEN-1:0] res_o,
    output logic            dz_o
);

    logic b_zero;
    assign b_zero = (b_i == '0);

    always_comb begin
        res_o = '0;
        dz_o  = 1'b0;
        unique case (op_i)
            VOP_ADD: res_o = a_i + b_i;
            VOP_SUB: res_o = a_i - b_i;
            VOP_MUL: res_o = a_i * b_i;
            VOP_DIV: begin
                dz_o  = b_zero;
                res_o = b_zero ? '0 : a_i / b_i;
            end
            default: res_o = '0;
        endcase
    end

endmodule

// File: rtl/vector_lane_sequencer.sv
// Time-multiplexes one lane ALU across all vector lanes, one lane per cycle.
// Optional per-lane divide-by-zero flags under VSEQ_DIVZERO_FLAG_EN.
module vector_lane_sequencer
    import vseq_pkg::*;
#(
    parameter int LANES = LANES_DEF,
    parameter int XLEN  = XLEN_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [2:0]            op,
    input  logic [LANES*XLEN-1:0] vs1,
    input  logic [LANES*XLEN-1:0] vs2,
    input  logic [4:0]            vd_idx,
    output logic                  busy,
    output logic                  stall,
    output logic                  wb_en,
    output logic [4:0]            wb_idx,
    output logic [LANES*XLEN-1:0] wb_data,
`ifdef VSEQ_DIVZERO_FLAG_EN
    output logic [LANES-1:0]      divz,
`endif
    output logic                  done
);

    localparam int VW = LANES * XLEN;
    localparam int CW = (LANES > 1) ? $clog2(LANES) : 1;

    vseq_state_e     state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [VW-1:0]   vs1_q, vs1_d;
    logic [VW-1:0]   vs2_q, vs2_d;
    logic [2:0]      op_q, op_d;
    logic [4:0]      vd_q, vd_d;
    logic [VW-1:0]   res_q, res_d;
    logic [LANES-1:0] divz_q, divz_d;

    logic [XLEN-1:0] lane_a, lane_b, lane_res;
    logic            lane_dz;

    always_comb begin
        lane_a = '0;
        lane_b = '0;
        for (int i = 0; i < LANES; i++) begin
            if (cnt_q == CW'(i)) begin
                lane_a = vs1_q[i*XLEN +: XLEN];
                lane_b = vs2_q[i*XLEN +: XLEN];
            end
        end
    end

    vlane_alu #(.XLEN(XLEN)) u_alu (
        .op_i  (op_q),
        .a_i   (lane_a),
        .b_i   (lane_b),
        .res_o (lane_res),
        .dz_o  (lane_dz)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        vs1_d   = vs1_q;
        vs2_d   = vs2_q;
        op_d    = op_q;
        vd_d    = vd_q;
        res_d   = res_q;
        divz_d  = divz_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    vs1_d   = vs1;
                    vs2_d   = vs2;
                    op_d    = op;
                    vd_d    = vd_idx;
                    res_d   = '0;
                    divz_d  = '0;
                end
            end
            RUN: begin
                for (int i = 0; i < LANES; i++) begin
                    if (cnt_q == CW'(i)) begin
                        res_d[i*XLEN +: XLEN] = lane_res;
                        divz_d[i]             = lane_dz;
                    end
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(LANES - 1)) begin
                    state_d = WB;
                    cnt_d   = '0;
                end
            end
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            vs1_q   <= '0;
            vs2_q   <= '0;
            op_q    <= '0;
            vd_q    <= '0;
            res_q   <= '0;
            divz_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vs1_q   <= vs1_d;
            vs2_q   <= vs2_d;
            op_q    <= op_d;
            vd_q    <= vd_d;
            res_q   <= res_d;
            divz_q  <= divz_d;
        end
    end

    assign busy    = (state_q == RUN) || (state_q == WB);
    assign stall   = (start && (state_q == IDLE)) || busy;
    assign wb_en   = (state_q == WB);
    assign done    = (state_q == WB);
    assign wb_idx  = vd_q;
    assign wb_data = res_q;

`ifdef VSEQ_DIVZERO_FLAG_EN
    assign divz = divz_q;
`else
    // Flag state is kept but never observed in this build.
    logic [LANES:0] unused_dz;
    assign unused_dz = {lane_dz, divz_q};
`endif

endmodule

// File: tb/tb_vector_lane_sequencer.sv
// Directed + randomized bench for vector_lane_sequencer,
// checked against a lane-level arithmetic reference model.
module tb_vector_lane_sequencer;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [2:0]   op;
    logic [127:0] vs1, vs2;
    logic [4:0]   vd_idx;
    logic         busy, stall, wb_en, done;
    logic [4:0]   wb_idx;
    logic [127:0] wb_data;
`ifdef VSEQ_DIVZERO_FLAG_EN
    logic [3:0]   divz;
`endif

    int n_vec = 0;
    int n_err = 0;

    vector_lane_sequencer dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op      (op),
        .vs1     (vs1),
        .vs2     (vs2),
        .vd_idx  (vd_idx),
        .busy    (busy),
        .stall   (stall),
        .wb_en   (wb_en),
        .wb_idx  (wb_idx),
        .wb_data (wb_data),
`ifdef VSEQ_DIVZERO_FLAG_EN
        .divz    (divz),
`endif
        .done    (done)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] model(input logic [2:0] o,
                                           input logic [127:0] a,
                                           input logic [127:0] b);
        logic [127:0] r;
        longint unsigned x, y, z;
        r = '0;
        for (int l = 0; l < 4; l++) begin
            x = longint'(a[l*32 +: 32]);
            y = longint'(b[l*32 +: 32]);
            case (o)
                3'b000:  z = x + y;
                3'b010:  z = x - y;
                3'b001:  z = x * y;
                3'b011:  z = (y == 0) ? 0 : x / y;
                default: z = 0;
            endcase
            r[l*32 +: 32] = z[31:0];
        end
        return r;
    endfunction

    function automatic logic [3:0] dz_model(input logic [2:0] o,
                                            input logic [127:0] b);
        logic [3:0] f;
        f = '0;
        for (int l = 0; l < 4; l++)
            f[l] = (o == 3'b011) && (b[l*32 +: 32] == 32'd0);
        return f;
    endfunction

    task automatic chk_b(input string tag, input logic obs, input logic want);
        n_vec++;
        assert (obs === want) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, want);
        end
    endtask

    task automatic chk_v(input string tag, input logic [127:0] obs,
                         input logic [127:0] want);
        n_vec++;
        assert (obs === want) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, want);
        end
    endtask

    function automatic logic [127:0] junk();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One op from accept (cycle T) through write-back (T+5) to idle (T+6).
    task automatic run_op(input logic [2:0] o, input logic [127:0] a,
                          input logic [127:0] b, input logic [4:0] idx);
        logic [127:0] want;
        logic [3:0]   wdz;
        want = model(o, a, b);
        wdz  = dz_model(o, b);
        @(negedge clk);
        start = 1'b1; op = o; vs1 = a; vs2 = b; vd_idx = idx;
        #1 chk_b("stall_req", stall, 1'b1);
        @(negedge clk);
        start = 1'b0; op = 3'($urandom); vs1 = junk(); vs2 = junk();
        vd_idx = 5'($urandom);
        for (int k = 1; k <= 5; k++) begin
            #1;
            chk_b("busy_run", busy, 1'b1);
            chk_b("wb_en_t", wb_en, k == 5);
            chk_b("done_t", done, k == 5);
            if (k == 5) begin
                chk_v("wb_data", wb_data, want);
                chk_v("wb_idx", 128'(wb_idx), 128'(idx));
`ifdef VSEQ_DIVZERO_FLAG_EN
                chk_v("divz", 128'(divz), 128'(wdz));
`endif
            end
            @(negedge clk);
        end
        #1;
        chk_b("busy_end", busy, 1'b0);
        chk_b("wb_en_end", wb_en, 1'b0);
        chk_b("stall_end", stall, 1'b0);
    endtask

    initial begin
        logic [127:0] a, b, want;
        logic [2:0]   o;
        int           la;
        logic         bexp, wexp;

        rst = 1'b1; start = 1'b0; op = '0; vs1 = '0; vs2 = '0; vd_idx = '0;
        repeat (3) @(negedge clk);
        #1;
        chk_b("rst_busy", busy, 1'b0);
        chk_b("rst_stall", stall, 1'b0);
        chk_b("rst_wb_en", wb_en, 1'b0);
        chk_b("rst_done", done, 1'b0);
        chk_v("rst_wb_idx", 128'(wb_idx), 128'd0);
        chk_v("rst_wb_data", wb_data, 128'd0);
        rst = 1'b0;

        run_op(3'b000, {32'd4, 32'd3, 32'd2, 32'd1},
               {32'd40, 32'd30, 32'd20, 32'd10}, 5'd5);
        chk_v("add_const", wb_data, {32'd44, 32'd33, 32'd22, 32'd11});
        run_op(3'b010, {32'd9, 32'd5, 32'd100, 32'd0},
               {32'd3, 32'd7, 32'd1, 32'd1}, 5'd7);
        chk_v("sub_wrap", 128'(wb_data[31:0]), 128'(32'hFFFF_FFFF));
        run_op(3'b001, {32'd3, 32'hFFFF_FFFF, 32'd7, 32'd10000},
               {32'd5, 32'd2, 32'd0, 32'd10000}, 5'd9);
        chk_v("mul_lo", 128'(wb_data[31:0]), 128'(32'h05F5_E100));
        run_op(3'b011, {32'd100, 32'd7, 32'd9, 32'd8},
               {32'd0, 32'd2, 32'd3, 32'd8}, 5'd3);
        chk_v("div_const", wb_data, {32'd0, 32'd3, 32'd3, 32'd1});
        run_op(3'b111, junk(), junk(), 5'd12);
        run_op(3'b000, junk(), junk(), 5'd0);

        // start held for 10 cycles; schedule derived from the latency rule
        a = junk(); b = junk(); want = model(3'b001, a, b);
        la = -100;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            start = (k < 10); op = 3'b001; vs1 = a; vs2 = b; vd_idx = 5'd17;
            bexp = (k >= la + 1) && (k <= la + 5);
            wexp = (k == la + 5);
            #1;
            chk_b("held_busy", busy, bexp);
            chk_b("held_stall", stall, bexp || start);
            chk_b("held_wb_en", wb_en, wexp);
            if (wexp) chk_v("held_data", wb_data, want);
            if (start && !bexp) la = k;
        end
        start = 1'b0;

        // reset mid-RUN aborts the op
        @(negedge clk);
        start = 1'b1; op = 3'b000; vs1 = junk(); vs2 = junk(); vd_idx = 5'd21;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_b("abort_busy", busy, 1'b0);
        chk_b("abort_wb_en", wb_en, 1'b0);
        chk_v("abort_data", wb_data, 128'd0);
        chk_v("abort_idx", 128'(wb_idx), 128'd0);
        repeat (5) begin
            @(negedge clk);
            #1 chk_b("abort_no_wb", wb_en, 1'b0);
        end
        run_op(3'b000, {32'd1, 32'd2, 32'd3, 32'd4},
               {32'd10, 32'd20, 32'd30, 32'd40}, 5'd8);

        // start and reset together: reset wins
        @(negedge clk);
        start = 1'b1; rst = 1'b1;
        @(negedge clk);
        start = 1'b0; rst = 1'b0;
        #1 chk_b("rst_start_busy", busy, 1'b0);
        repeat (6) begin
            @(negedge clk);
            #1 chk_b("rst_start_no_wb", wb_en, 1'b0);
        end

        for (int n = 0; n < 24; n++) begin
            case ($urandom_range(0, 4))
                0:       o = 3'b000;
                1:       o = 3'b001;
                2:       o = 3'b010;
                3:       o = 3'b011;
                default: o = 3'($urandom_range(4, 7));
            endcase
            a = junk(); b = junk();
            for (int l = 0; l < 4; l++) begin
                if ($urandom_range(0, 3) == 0) b[l*32 +: 32] = 32'd0;
                else if ($urandom_range(0, 1) == 0)
                    b[l*32 +: 32] = 32'($urandom_range(1, 9));
            end
            run_op(o, a, b, 5'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
